upg_mem_arb: RTL

UPG_MEM_ARB -- requirements
Module: upg_mem_arb

---
 rtl/upg_mem_arb.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/upg_mem_arb.sv
// Memory arbiter between the upgrade programmer port and the CPU.
// The programmer owns the RAM while a session is open; otherwise the CPU
// gets single-cycle writes and two-cycle reads (synchronous RAM read).
module upg_mem_arb (
  input  logic        clock,
  input  logic        reset_n,
  // programmer port
  input  logic        upg_active_i,
  input  logic        upg_wen_i,
  input  logic [14:0] upg_adr_i,
  input  logic [31:0] upg_dat_i,
  input  logic        upg_done_i,
  // CPU port
  input  logic        run_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [13:0] cpu_adr_i,
  input  logic [31:0] cpu_dat_i,
  output logic [31:0] cpu_rdat_o,
  output logic        cpu_ack_o,
  output logic        cpu_hold_o,
  // RAM port
  output logic        ram_we_o,
  output logic [13:0] ram_adr_o,
  output logic [31:0] ram_dat_o,
  input  logic [31:0] ram_rdat_i,
  // session status
  output logic [13:0] prog_cnt_o,
  output logic        prog_abort_o
);

  typedef enum logic [1:0] {
    S_HOLD,
    S_PROG,
    S_RUN,
    S_RD
  } state_e;

  state_e      state_q, state_d;
  logic        ack_q, ack_d;       // read-completion ack, shown the cycle after RD
  logic [31:0] rdat_q, rdat_d;
  logic [13:0] cnt_q, cnt_d;
  logic        abort_q, abort_d;
  logic        wr_ack;

  // Next-state, RAM steering and status updates
  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    rdat_d     = rdat_q;
    cnt_d      = cnt_q;
    abort_d    = abort_q;
    ram_we_o   = 1'b0;
    ram_adr_o  = cpu_adr_i;
    ram_dat_o  = cpu_dat_i;
    cpu_hold_o = 1'b1;
    wr_ack     = 1'b0;

    unique case (state_q)
      S_HOLD: begin
        if (upg_active_i) begin
          state_d = S_PROG;
          cnt_d   = '0;
          abort_d = 1'b0;
        end else if (run_i) begin
          state_d = S_RUN;
        end
      end

      S_PROG: begin
        ram_adr_o = upg_adr_i[13:0];
        ram_dat_o = upg_dat_i;
        // Only data-memory words reach the RAM; a write concurrent with
        // done still lands and counts.
        if (upg_wen_i && upg_adr_i[14]) begin
          ram_we_o = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 14'd1;
        end
        if (upg_done_i) begin
          state_d = S_RUN;
        end else if (!upg_active_i) begin
          state_d = S_HOLD;
          abort_d = 1'b1;
        end
      end

      S_RUN: begin
        // A request still present during the ack cycle is the read being
        // completed (CPU is frozen until this edge), not a new access.
        cpu_hold_o = cpu_req_i && !cpu_we_i && !ack_q;
        if (upg_active_i) begin
          // Entering PROG from RUN also starts a fresh session.
          state_d = S_PROG;
          cnt_d   = '0;
          abort_d = 1'b0;
        end else if (cpu_req_i && !ack_q) begin
          if (cpu_we_i) begin
            ram_we_o = 1'b1;
            wr_ack   = 1'b1;
          end else begin
            state_d = S_RD;
          end
        end
      end

      S_RD: begin
        if (upg_active_i) begin
          // Read data is discarded and no ack is given.
          state_d = S_PROG;
          cnt_d   = '0;
          abort_d = 1'b0;
        end else begin
          rdat_d  = ram_rdat_i;
          ack_d   = 1'b1;
          state_d = S_RUN;
        end
      end

      default: state_d = S_HOLD;
    endcase
  end

  // State and status registers, asynchronously reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_HOLD;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign cpu_ack_o    = ack_q | wr_ack;
  assign cpu_rdat_o   = rdat_q;
  assign prog_cnt_o   = cnt_q;
  assign prog_abort_o = abort_q;

endmodule
